// File: rtl/cpu_pkg.sv
// Shared definitions for the five-bit-opcode pipeline: next-PC selects, fetch FSM
// encoding and instruction field positions.
package cpu_pkg;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RET    = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_START = 2'd0,
        FS_RUN   = 2'd1,
        FS_HALT  = 2'd2
    } fetch_state_e;

    localparam int STOP_BIT   = 31;
    localparam int TYPE_MSB   = 30;
    localparam int TYPE_LSB   = 29;
    localparam int OPCODE_MSB = 4;
    localparam int OPCODE_LSB = 0;

    function automatic logic is_stop(input logic [31:0] instr);
        return instr[STOP_BIT];
    endfunction

endpackage

// File: rtl/fetch_pc_select.sv
// Combinational next-PC mux: sequential +1 (wrapping mod 2^32) or one of three
// redirect targets chosen by pc_src.
module fetch_pc_select
    import cpu_pkg::*;
(
    input  logic [1:0]  pc_src,
    input  logic [31:0] pc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] return_target,
    output logic [31:0] pc_seq,
    output logic [31:0] pc_sel
);

    assign pc_seq = pc + 32'd1;

    always_comb begin
        pc_sel = pc_seq;
        case (pc_src)
            PC_SRC_BRANCH: pc_sel = branch_target;
            PC_SRC_JUMP:   pc_sel = jump_target;
            PC_SRC_RET:    pc_sel = return_target;
            default:       pc_sel = pc_seq;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, START/RUN/HALT FSM and IF/ID register.
// Define HALT_ON_STOP_EN to build stop-bit detection and the HALT state.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] return_target,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC_Reg,
    output logic [31:0] PC_Next,
    output logic        valid,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  pc_seq;
    logic [31:0]  pc_sel;
    logic         active;
    logic         stop_accept;

    // Handshake: a fetch is issued in any cycle imem_en=1; its data arrives next
    // cycle and is kept live in IF/ID only if that cycle saw no flush, redirect or stop.
    fetch_pc_select u_pc_select (
        .pc_src        (pc_src),
        .pc            (pc),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .return_target (return_target),
        .pc_seq        (pc_seq),
        .pc_sel        (pc_sel)
    );

    assign active      = (state != FS_HALT);
    assign imem_en     = active & ~stall & ~rst;
    assign imem_addr   = pc;
    assign Instruction = valid ? imem_rdata : NOP_INSTR;
    assign dbg_state   = state;

`ifdef HALT_ON_STOP_EN
    assign stop_accept = valid & is_stop(imem_rdata) & ~stall & ~flush;
    assign halted      = (state == FS_HALT);
`else
    assign stop_accept = 1'b0;
    assign halted      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FS_START;
            pc      <= RESET_PC;
            valid   <= 1'b0;
            PC_Reg  <= 32'h0;
            PC_Next <= 32'h0;
        end else begin
            case (state)
                FS_START: state <= FS_RUN;
                FS_RUN:   if (stop_accept) state <= FS_HALT;
                default:  state <= state;
            endcase

            if (active && !stall)
                pc <= pc_sel;

            if (!stall) begin
                PC_Reg  <= pc;
                PC_Next <= pc_seq;
                valid   <= imem_en & ~flush & (pc_src == PC_SRC_SEQ) & ~stop_accept;
            end else if (flush) begin
                // Flush still kills the held instruction while the PC and PC_Reg stay put.
                valid <= 1'b0;
            end
        end
    end

endmodule
